// File: rtl/maze_dfs_controller.sv
// Depth-first maze solver: probes neighbours through a 1-cycle wall memory,
// keeps taken directions on a stack, then streams the path out.
module maze_dfs_controller #(
   parameter int N  = 16,
   parameter int AW = $clog2(N),
   parameter int SD = N * N
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic [AW-1:0] mem_row,
   output logic [AW-1:0] mem_col,
   output logic          mem_rd,
   input  logic          mem_wall,
   output logic          busy,
   output logic [AW-1:0] cur_row,
   output logic [AW-1:0] cur_col,
   output logic          path_valid,
   input  logic          path_ready,
   output logic [1:0]    path_dir,
   output logic          path_last,
   output logic          done,
   output logic          fail
);

   localparam int CW = $clog2(SD);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_EVAL, S_MOVE,
      S_BACK, S_DUMP, S_DONE, S_FAIL
   } state_t;

   state_t        state, state_n;
   logic [AW-1:0] row_n, col_n;
   logic [1:0]    dir, dir_n;
   logic [CW-1:0] sp, sp_n;
   logic [CW-1:0] idx, idx_n;
   logic [SD-1:0] visited;
   logic [1:0]    stack [SD];

   logic [AW-1:0] nb_row, nb_col;
   logic [AW-1:0] bk_row, bk_col;
   logic [CW-1:0] nb_cell;
   logic [1:0]    top;
   logic          oob, blocked, goal;
   logic          push, mark, clear;

   // neighbour in the probe direction, with edge detection (no wrap)
   always_comb begin
      nb_row = cur_row;
      nb_col = cur_col;
      oob    = 1'b0;
      unique case (dir)
         2'd0: if (cur_col == AW'(N-1)) oob = 1'b1;
               else nb_col = cur_col + AW'(1);
         2'd1: if (cur_row == AW'(N-1)) oob = 1'b1;
               else nb_row = cur_row + AW'(1);
         2'd2: if (cur_row == '0) oob = 1'b1;
               else nb_row = cur_row - AW'(1);
         2'd3: if (cur_col == '0) oob = 1'b1;
               else nb_col = cur_col - AW'(1);
      endcase
   end

   assign nb_cell = CW'(nb_row) * CW'(N) + CW'(nb_col);
   assign blocked = oob || visited[nb_cell];
   assign goal    = (nb_row == AW'(N-1)) && (nb_col == AW'(N-1));
   assign top     = stack[sp - CW'(1)];

   // reverse of d is ~d, so undo the popped move by stepping ~top
   always_comb begin
      bk_row = cur_row;
      bk_col = cur_col;
      unique case (~top)
         2'd0: bk_col = cur_col + AW'(1);
         2'd1: bk_row = cur_row + AW'(1);
         2'd2: bk_row = cur_row - AW'(1);
         2'd3: bk_col = cur_col - AW'(1);
      endcase
   end

   always_comb begin
      state_n = state;
      row_n   = cur_row;
      col_n   = cur_col;
      dir_n   = dir;
      sp_n    = sp;
      idx_n   = idx;
      push    = 1'b0;
      mark    = 1'b0;
      clear   = 1'b0;
      mem_rd  = 1'b0;
      unique case (state)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               clear   = 1'b1;
               row_n   = '0;
               col_n   = '0;
               dir_n   = 2'd0;
               sp_n    = '0;
               idx_n   = '0;
               state_n = S_CHECK;
            end
         end
         S_CHECK: begin
            if (blocked) begin
               if (dir != 2'd3) dir_n = dir + 2'd1;
               else state_n = S_BACK;
            end else begin
               mem_rd  = 1'b1;
               state_n = S_EVAL;
            end
         end
         S_EVAL: begin
            if (mem_wall) begin
               if (dir != 2'd3) begin
                  dir_n   = dir + 2'd1;
                  state_n = S_CHECK;
               end else begin
                  state_n = S_BACK;
               end
            end else begin
               state_n = S_MOVE;
            end
         end
         S_MOVE: begin
            push  = 1'b1;
            mark  = 1'b1;
            sp_n  = sp + CW'(1);
            row_n = nb_row;
            col_n = nb_col;
            dir_n = 2'd0;
            idx_n = '0;
            state_n = goal ? S_DUMP : S_CHECK;
         end
         S_BACK: begin
            if (sp == '0) begin
               state_n = S_FAIL;
            end else begin
               sp_n  = sp - CW'(1);
               row_n = bk_row;
               col_n = bk_col;
               if (top != 2'd3) begin
                  dir_n   = top + 2'd1;
                  state_n = S_CHECK;
               end
            end
         end
         S_DUMP: begin
            if (path_ready) begin
               idx_n = idx + CW'(1);
               if (path_last) state_n = S_DONE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cur_row <= '0;
         cur_col <= '0;
         dir     <= 2'd0;
         sp      <= '0;
         idx     <= '0;
         visited <= '0;
      end else begin
         state   <= state_n;
         cur_row <= row_n;
         cur_col <= col_n;
         dir     <= dir_n;
         sp      <= sp_n;
         idx     <= idx_n;
         if (clear)
            visited <= {{(SD-1){1'b0}}, 1'b1};
         else if (mark)
            visited[nb_cell] <= 1'b1;
      end
   end

   // stack contents are only meaningful below sp, so no reset needed
   always_ff @(posedge clk) begin
      if (push) stack[sp] <= dir;
   end

   assign mem_row    = mem_rd ? nb_row : '0;
   assign mem_col    = mem_rd ? nb_col : '0;
   assign busy       = (state == S_CHECK) || (state == S_EVAL) ||
                       (state == S_MOVE)  || (state == S_BACK) ||
                       (state == S_DUMP);
   assign done       = (state == S_DONE);
   assign fail       = (state == S_FAIL);
   assign path_valid = (state == S_DUMP);
   assign path_dir   = path_valid ? stack[idx] : 2'd0;
   assign path_last  = path_valid && (idx == sp - CW'(1));

endmodule

// File: tb/tb_maze_dfs_controller.sv
// Scoreboard bench for maze_dfs_controller on a 4x4 maze with a
// behavioural 1-cycle-latency wall memory.
module tb_maze_dfs_controller;

   localparam int N  = 4;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          mem_wall = 1'b0;
   logic          path_ready = 1'b0;
   logic [AW-1:0] mem_row, mem_col, cur_row, cur_col;
   logic          mem_rd, busy, path_valid, path_last, done, fail;
   logic [1:0]    path_dir;

   logic [15:0]   walls = '0;
   int            probes = 0;
   int            pass_cnt = 0;
   int            chk_cnt = 0;
   logic [1:0]    exp_q[$];

   maze_dfs_controller #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_row(mem_row), .mem_col(mem_col), .mem_rd(mem_rd),
      .mem_wall(mem_wall), .busy(busy),
      .cur_row(cur_row), .cur_col(cur_col),
      .path_valid(path_valid), .path_ready(path_ready),
      .path_dir(path_dir), .path_last(path_last),
      .done(done), .fail(fail)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd) begin
         mem_wall <= walls[{mem_row, mem_col}];
         probes   <= probes + 1;
      end else begin
         mem_wall <= 1'b0;
      end
   end

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic load_clear_path();
      exp_q.delete();
      exp_q.push_back(2'd0); exp_q.push_back(2'd0);
      exp_q.push_back(2'd0); exp_q.push_back(2'd1);
      exp_q.push_back(2'd1); exp_q.push_back(2'd1);
   endtask

   // runs until done/fail, popping the scoreboard on every handshake
   task automatic run_to_end(input bit bp, output int hs, output int vcyc);
      int cyc = 0;
      int pat = 0;
      bit stalled = 1'b0;
      bit ended = 1'b0;
      logic [1:0] hdir = 2'd0;
      logic hlast = 1'b0;
      logic [1:0] e;
      hs = 0;
      vcyc = 0;
      while (cyc < 600 && !ended) begin
         if (done || fail) begin
            ended = 1'b1;
         end else begin
            if (path_valid) begin
               vcyc++;
               path_ready = bp ? ((pat % 4 == 0) || (pat % 4 == 3)) : 1'b1;
               pat++;
               if (stalled) begin
                  chk_cnt++;
                  if (path_dir !== hdir || path_last !== hlast)
                     $display("FAIL stall_hold dir=%0d last=%b want %0d %b",
                              path_dir, path_last, hdir, hlast);
                  else pass_cnt++;
               end
               if (path_ready) begin
                  chk_cnt++;
                  if (exp_q.size() == 0) begin
                     $display("FAIL extra_entry dir=%0d want none", path_dir);
                  end else begin
                     e = exp_q.pop_front();
                     if (path_dir !== e || path_last !== (exp_q.size() == 0))
                        $display("FAIL path_entry%0d dir=%0d last=%b want %0d %b",
                                 hs, path_dir, path_last, e, exp_q.size() == 0);
                     else pass_cnt++;
                  end
                  hs++;
               end
               stalled = !path_ready;
               hdir = path_dir;
               hlast = path_last;
            end else begin
               path_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      path_ready = 1'b0;
      if (!ended) begin
         chk_cnt++;
         $display("FAIL timeout got no done/fail want end within 600 cycles");
      end
   endtask

   task automatic check_solved(input string name, input int hs, input int np, input int base);
      chk_cnt++;
      if (done !== 1'b1 || fail !== 1'b0 || busy !== 1'b0 || path_valid !== 1'b0)
         $display("FAIL %s_flags done=%b fail=%b busy=%b pv=%b want 1 0 0 0",
                  name, done, fail, busy, path_valid);
      else pass_cnt++;
      chk_cnt++;
      if (hs !== 6 || exp_q.size() != 0)
         $display("FAIL %s_count hs=%0d left=%0d want 6 0", name, hs, exp_q.size());
      else pass_cnt++;
      chk_cnt++;
      if (probes - base !== np)
         $display("FAIL %s_probes got %0d want %0d", name, probes - base, np);
      else pass_cnt++;
      chk_cnt++;
      if (cur_row !== 2'd3 || cur_col !== 2'd3)
         $display("FAIL %s_pos got (%0d,%0d) want (3,3)", name, cur_row, cur_col);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if ({busy, done, fail, path_valid, path_last, mem_rd} !== 6'b0)
         $display("FAIL reset_flags got %b want 000000",
                  {busy, done, fail, path_valid, path_last, mem_rd});
      else pass_cnt++;
      chk_cnt++;
      if ({cur_row, cur_col, mem_row, mem_col, path_dir} !== 10'b0)
         $display("FAIL reset_bus got %h want 0",
                  {cur_row, cur_col, mem_row, mem_col, path_dir});
      else pass_cnt++;
   endtask

   task automatic test_empty_maze();
      int hs, vc, base;
      walls = '0;
      load_clear_path();
      base = probes;
      pulse_start();
      chk_cnt++;
      if (busy !== 1'b1) $display("FAIL empty_busy got %b want 1", busy);
      else pass_cnt++;
      run_to_end(1'b0, hs, vc);
      check_solved("empty", hs, 6, base);
   endtask

   task automatic test_no_path();
      int hs, vc, base;
      walls = '0;
      walls[1] = 1'b1;
      walls[4] = 1'b1;
      exp_q.delete();
      base = probes;
      pulse_start();
      run_to_end(1'b0, hs, vc);
      chk_cnt++;
      if (fail !== 1'b1 || done !== 1'b0 || busy !== 1'b0)
         $display("FAIL nopath_flags fail=%b done=%b busy=%b want 1 0 0",
                  fail, done, busy);
      else pass_cnt++;
      chk_cnt++;
      if (probes - base !== 2 || vc !== 0)
         $display("FAIL nopath_probes got %0d pv=%0d want 2 0", probes - base, vc);
      else pass_cnt++;
   endtask

   task automatic test_restart_from_fail();
      int hs, vc, base;
      walls = '0;
      load_clear_path();
      base = probes;
      pulse_start();
      chk_cnt++;
      if (fail !== 1'b0 || busy !== 1'b1 || cur_row !== 2'd0 || cur_col !== 2'd0)
         $display("FAIL restart got fail=%b busy=%b (%0d,%0d) want 0 1 (0,0)",
                  fail, busy, cur_row, cur_col);
      else pass_cnt++;
      run_to_end(1'b0, hs, vc);
      check_solved("restart", hs, 6, base);
   endtask

   task automatic test_backtrack();
      int hs, vc, base;
      walls = '0;
      walls[5] = 1'b1;
      walls[6] = 1'b1;
      walls[7] = 1'b1;
      exp_q.delete();
      exp_q.push_back(2'd1); exp_q.push_back(2'd1);
      exp_q.push_back(2'd0); exp_q.push_back(2'd0);
      exp_q.push_back(2'd0); exp_q.push_back(2'd1);
      base = probes;
      pulse_start();
      run_to_end(1'b0, hs, vc);
      check_solved("backtrack", hs, 13, base);
   endtask

   task automatic test_backpressure();
      int hs, vc, base;
      walls = '0;
      load_clear_path();
      base = probes;
      pulse_start();
      run_to_end(1'b1, hs, vc);
      check_solved("bp", hs, 6, base);
      chk_cnt++;
      if (vc !== 12) $display("FAIL bp_valid_cycles got %0d want 12", vc);
      else pass_cnt++;
   endtask

   task automatic test_start_while_busy();
      int hs, vc, base;
      walls = '0;
      load_clear_path();
      base = probes;
      pulse_start();
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      run_to_end(1'b0, hs, vc);
      check_solved("busy_start", hs, 6, base);
   endtask

   task automatic test_reset_mid_solve();
      int hs, vc, base, n;
      walls = '0;
      exp_q.delete();
      pulse_start();
      n = 0;
      while (cur_col !== 2'd3 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk_cnt++;
      if (n >= 50) $display("FAIL midrst_reach got col=%0d want 3", cur_col);
      else pass_cnt++;
      rst = 1'b1;
      #1;
      chk_cnt++;
      if ({busy, done, fail, path_valid, mem_rd, cur_row, cur_col} !== 9'b0)
         $display("FAIL midrst_outputs got %b want 0",
                  {busy, done, fail, path_valid, mem_rd, cur_row, cur_col});
      else pass_cnt++;
      base = probes;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if (probes !== base) $display("FAIL midrst_probes got %0d want 0", probes - base);
      else pass_cnt++;
      rst = 1'b0;
      load_clear_path();
      base = probes;
      pulse_start();
      run_to_end(1'b0, hs, vc);
      check_solved("after_rst", hs, 6, base);
   endtask

   initial begin
      test_reset();
      test_empty_maze();
      test_no_path();
      test_restart_from_fail();
      test_backtrack();
      test_backpressure();
      test_start_while_busy();
      test_reset_mid_solve();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
